// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches execute results, owns the V/Z/N flags and resolves branches/jumps
// into a registered PC redirect. Optional branch counters under `ifdef BRANCH_STATS_EN.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush_in,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_v,
  input  logic              ex_z,
  input  logic              ex_n,
  input  logic              ex_flag_we,
  input  logic              ex_branch,
  input  logic [2:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic              ex_jump,
  input  logic [DATA_W-1:0] ex_jmp_target,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic              ex_rf_we,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic              ex_halt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              mem_re,
  output logic              mem_we,
  output logic              mem_rf_we,
  output logic [REG_W-1:0]  mem_dst,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_n,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
`ifdef BRANCH_STATS_EN
  output logic [15:0]       br_total,
  output logic [15:0]       br_taken,
`endif
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              accept, cond_true, taken;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] alu_q, alu_d, store_q, store_d, rpc_q, rpc_d;
  logic              re_q, re_d, we_q, we_d, rfwe_q, rfwe_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic              v_q, v_d, z_q, z_d, n_q, n_d;

  // Branch conditions evaluate against the architectural (registered) flags
  always_comb begin
    cond_true = 1'b0;
    unique case (ex_cond)
      3'b000:  cond_true = ~z_q;
      3'b001:  cond_true = z_q;
      3'b010:  cond_true = ~z_q & ~n_q;
      3'b011:  cond_true = n_q;
      3'b100:  cond_true = z_q | ~n_q;
      3'b101:  cond_true = z_q | n_q;
      3'b110:  cond_true = v_q;
      default: cond_true = 1'b1;
    endcase
    accept = ex_valid & ~stall & ~flush_in & (state_q == ST_RUN);
    taken  = accept & (ex_jump | (ex_branch & cond_true));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Halt takes priority over a taken branch in the same instruction
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept && ex_halt) state_d = ST_HALTED;
        else if (taken)        state_d = ST_SQUASH;
      end
      ST_SQUASH: if (!stall) state_d = ST_RUN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    redirect = (state_q == ST_SQUASH);
    halted   = (state_q == ST_HALTED);
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    re_d        = re_q;
    we_d        = we_q;
    rfwe_d      = rfwe_q;
    alu_d       = alu_q;
    store_d     = store_q;
    dst_d       = dst_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    rpc_d       = rpc_q;
    if (!stall) begin
      mem_valid_d = accept;
      re_d        = accept & ex_mem_re;
      we_d        = accept & ex_mem_we;
      rfwe_d      = accept & ex_rf_we;
    end
    if (accept) begin
      alu_d   = ex_alu_result;
      store_d = ex_store_data;
      dst_d   = ex_dst;
      if (ex_flag_we) begin
        v_d = ex_v;
        z_d = ex_z;
        n_d = ex_n;
      end
    end
    if (taken && !ex_halt) rpc_d = ex_jump ? ex_jmp_target : ex_br_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      rfwe_q      <= 1'b0;
      alu_q       <= '0;
      store_q     <= '0;
      dst_q       <= '0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      rpc_q       <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      re_q        <= re_d;
      we_q        <= we_d;
      rfwe_q      <= rfwe_d;
      alu_q       <= alu_d;
      store_q     <= store_d;
      dst_q       <= dst_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      rpc_q       <= rpc_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_alu_result = alu_q;
  assign mem_store_data = store_q;
  assign mem_re         = re_q;
  assign mem_we         = we_q;
  assign mem_rf_we      = rfwe_q;
  assign mem_dst        = dst_q;
  assign flag_v         = v_q;
  assign flag_z         = z_q;
  assign flag_n         = n_q;
  assign redirect_pc    = rpc_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] br_total_q, br_total_d, br_taken_q, br_taken_d;

  // Saturating counters; accept is already 0 under stall so they hold
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (accept && (ex_branch || ex_jump) && br_total_q != 16'hFFFF)
      br_total_d = 16'(br_total_q + 16'd1);
    if (taken && br_taken_q != 16'hFFFF)
      br_taken_d = 16'(br_taken_q + 16'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic against a
// behavioural model of the pipeline register, flags and redirect.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush_in, ex_valid;
  logic [15:0] ex_alu_result, ex_br_target, ex_jmp_target, ex_store_data;
  logic        ex_v, ex_z, ex_n, ex_flag_we, ex_branch, ex_jump;
  logic [2:0]  ex_cond;
  logic        ex_mem_re, ex_mem_we, ex_rf_we, ex_halt;
  logic [3:0]  ex_dst;
  logic        mem_valid, mem_re, mem_we, mem_rf_we;
  logic [15:0] mem_alu_result, mem_store_data, redirect_pc;
  logic [3:0]  mem_dst;
  logic        flag_v, flag_z, flag_n, redirect, halted;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_total, br_taken;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_in(flush_in), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_v(ex_v), .ex_z(ex_z), .ex_n(ex_n),
    .ex_flag_we(ex_flag_we), .ex_branch(ex_branch), .ex_cond(ex_cond),
    .ex_br_target(ex_br_target), .ex_jump(ex_jump), .ex_jmp_target(ex_jmp_target),
    .ex_store_data(ex_store_data), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_rf_we(ex_rf_we), .ex_dst(ex_dst), .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rf_we(mem_rf_we), .mem_dst(mem_dst),
    .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef BRANCH_STATS_EN
    .br_total(br_total), .br_taken(br_taken),
`endif
    .halted(halted)
  );

  // Reference model state
  logic        m_valid, m_re, m_we, m_rfwe, m_v, m_z, m_n, m_squash, m_halted;
  logic [15:0] m_alu, m_store, m_rpc;
  logic [3:0]  m_dst;
  int          m_total, m_taken;

  function automatic logic cond_ok(input logic [2:0] c, input logic v, input logic z, input logic n);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return z || n;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    {m_valid, m_re, m_we, m_rfwe, m_v, m_z, m_n, m_squash, m_halted} = '0;
    m_alu = '0; m_store = '0; m_rpc = '0; m_dst = '0;
    m_total = 0; m_taken = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic acc, tk;
    if (stall) return;
    acc = ex_valid && !flush_in && !m_squash && !m_halted;
    tk  = acc && (ex_jump || (ex_branch && cond_ok(ex_cond, m_v, m_z, m_n)));
    if (acc && (ex_branch || ex_jump)) m_total = (m_total < 65535) ? m_total + 1 : 65535;
    if (tk) m_taken = (m_taken < 65535) ? m_taken + 1 : 65535;
    if (acc && ex_halt) begin
      m_halted = 1'b1;
    end else if (tk) begin
      m_squash = 1'b1;
      m_rpc = ex_jump ? ex_jmp_target : ex_br_target;
    end else begin
      m_squash = 1'b0;
    end
    m_valid = acc;
    m_re    = acc && ex_mem_re;
    m_we    = acc && ex_mem_we;
    m_rfwe  = acc && ex_rf_we;
    if (acc) begin
      m_alu = ex_alu_result; m_store = ex_store_data; m_dst = ex_dst;
      if (ex_flag_we) begin m_v = ex_v; m_z = ex_z; m_n = ex_n; end
    end
  endtask

  task automatic set_idle();
    stall = 0; flush_in = 0; ex_valid = 0; ex_alu_result = '0; ex_v = 0; ex_z = 0; ex_n = 0;
    ex_flag_we = 0; ex_branch = 0; ex_cond = '0; ex_br_target = '0; ex_jump = 0;
    ex_jmp_target = '0; ex_store_data = '0; ex_mem_re = 0; ex_mem_we = 0; ex_rf_we = 0;
    ex_dst = '0; ex_halt = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_idle();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({mem_valid, mem_re, mem_we, mem_rf_we, flag_v, flag_z, flag_n, redirect, halted} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {mem_valid, mem_re, mem_we, mem_rf_we, flag_v, flag_z, flag_n, redirect, halted});
    end
    checks++;
    if ({mem_alu_result, mem_store_data, redirect_pc, mem_dst} !== 52'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
        {mem_alu_result, mem_store_data, redirect_pc, mem_dst});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    set_idle();
    ex_valid = 1; ex_alu_result = 16'h1234; ex_flag_we = 1; ex_z = 0; ex_rf_we = 1; ex_dst = 4'd3;
    cycle();
    checks++;
    if ({mem_valid, mem_alu_result, flag_z, mem_rf_we, mem_dst} !== {1'b1, 16'h1234, 1'b0, 1'b1, 4'd3}) begin
      errors++; $display("FAIL alu_latch: valid=%b res=%h z=%b rfwe=%b dst=%0d expected 1 1234 0 1 3",
        mem_valid, mem_alu_result, flag_z, mem_rf_we, mem_dst);
    end
  endtask

  task automatic test_branch_eq();
    set_idle();
    ex_valid = 1; ex_alu_result = 16'h0000; ex_flag_we = 1; ex_z = 1;
    cycle();
    set_idle();
    ex_valid = 1; ex_branch = 1; ex_cond = 3'b001; ex_br_target = 16'h0040;
    cycle();
    checks++;
    if ({redirect, redirect_pc, mem_valid} !== {1'b1, 16'h0040, 1'b1}) begin
      errors++; $display("FAIL beq_redirect: redirect=%b pc=%h valid=%b expected 1 0040 1",
        redirect, redirect_pc, mem_valid);
    end
    set_idle();
    ex_valid = 1; ex_flag_we = 1; ex_z = 0; ex_n = 1; ex_rf_we = 1;
    cycle();
    checks++;
    if ({mem_valid, mem_rf_we, flag_z, flag_n, redirect} !== 5'b00100) begin
      errors++; $display("FAIL beq_squash: valid=%b rfwe=%b z=%b n=%b redirect=%b expected 0 0 1 0 0",
        mem_valid, mem_rf_we, flag_z, flag_n, redirect);
    end
  endtask

  task automatic test_branch_lt();
    set_idle();
    ex_valid = 1; ex_flag_we = 1;
    cycle();
    set_idle();
    ex_valid = 1; ex_branch = 1; ex_cond = 3'b011; ex_br_target = 16'h0777; ex_rf_we = 1; ex_dst = 4'd5;
    cycle();
    checks++;
    if ({redirect, mem_valid, mem_rf_we, mem_dst} !== {1'b0, 1'b1, 1'b1, 4'd5}) begin
      errors++; $display("FAIL blt_not_taken: redirect=%b valid=%b rfwe=%b dst=%0d expected 0 1 1 5",
        redirect, mem_valid, mem_rf_we, mem_dst);
    end
  endtask

  task automatic test_jump_stall();
    set_idle();
    ex_valid = 1; ex_jump = 1; ex_jmp_target = 16'h0100;
    ex_branch = 1; ex_cond = 3'b111; ex_br_target = 16'h0200;
    cycle();
    checks++;
    if ({redirect, redirect_pc} !== {1'b1, 16'h0100}) begin
      errors++; $display("FAIL jump_redirect: redirect=%b pc=%h expected 1 0100", redirect, redirect_pc);
    end
    set_idle();
    stall = 1; ex_valid = 1; ex_alu_result = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({redirect, redirect_pc, mem_valid} !== {1'b1, 16'h0100, 1'b1}) begin
        errors++; $display("FAIL jump_stall_%0d: redirect=%b pc=%h valid=%b expected 1 0100 1",
          i, redirect, redirect_pc, mem_valid);
      end
    end
    stall = 0; ex_alu_result = 16'h5555;
    cycle();
    checks++;
    if ({redirect, mem_valid} !== 2'b00) begin
      errors++; $display("FAIL jump_drop: redirect=%b valid=%b expected 0 0", redirect, mem_valid);
    end
    cycle();
    checks++;
    if ({mem_valid, mem_alu_result} !== {1'b1, 16'h5555}) begin
      errors++; $display("FAIL jump_resume: valid=%b res=%h expected 1 5555", mem_valid, mem_alu_result);
    end
  endtask

  task automatic test_flush_taken();
    set_idle();
    ex_valid = 1; ex_jump = 1; ex_jmp_target = 16'h0ABC; flush_in = 1;
    cycle();
    checks++;
    if ({redirect, mem_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_wins: redirect=%b valid=%b expected 0 0", redirect, mem_valid);
    end
  endtask

  task automatic test_halt();
    logic z_before;
    set_idle();
    ex_valid = 1; ex_halt = 1; ex_jump = 1; ex_jmp_target = 16'h0300;
    cycle();
    checks++;
    if ({halted, redirect, mem_valid} !== 3'b101) begin
      errors++; $display("FAIL halt_beats_jump: halted=%b redirect=%b valid=%b expected 1 0 1",
        halted, redirect, mem_valid);
    end
    z_before = flag_z;
    set_idle();
    ex_valid = 1; ex_flag_we = 1; ex_z = ~z_before;
    cycle();
    cycle();
    checks++;
    if ({halted, mem_valid, flag_z} !== {1'b1, 1'b0, z_before}) begin
      errors++; $display("FAIL halt_ignore: halted=%b valid=%b z=%b expected 1 0 %b",
        halted, mem_valid, flag_z, z_before);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: halted=%b expected 0", halted);
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    ex_valid = 1; ex_jump = 1; ex_jmp_target = 16'h0FF0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({redirect, mem_valid, redirect_pc} !== 18'h0) begin
      errors++; $display("FAIL reset_mid: redirect=%b valid=%b pc=%h expected 0 0 0000",
        redirect, mem_valid, redirect_pc);
    end
    model_reset();
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [60:0] obs, expv;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && $urandom_range(3, 0) == 0) || $urandom_range(499, 0) == 0) do_reset();
      stall         = ($urandom_range(4, 0) == 0);
      flush_in      = ($urandom_range(7, 0) == 0);
      ex_valid      = ($urandom_range(7, 0) != 0);
      ex_alu_result = 16'($urandom);
      ex_store_data = 16'($urandom);
      ex_br_target  = 16'($urandom);
      ex_jmp_target = 16'($urandom);
      {ex_v, ex_z, ex_n} = 3'($urandom);
      ex_flag_we    = ($urandom_range(1, 0) == 0);
      ex_branch     = ($urandom_range(3, 0) == 0);
      ex_jump       = ($urandom_range(7, 0) == 0);
      ex_cond       = 3'($urandom);
      ex_mem_re     = ($urandom_range(3, 0) == 0);
      ex_mem_we     = ($urandom_range(3, 0) == 0);
      ex_rf_we      = ($urandom_range(1, 0) == 0);
      ex_dst        = 4'($urandom);
      ex_halt       = ($urandom_range(63, 0) == 0);
      cycle();
      obs  = {mem_valid, mem_alu_result, mem_store_data, mem_re, mem_we, mem_rf_we, mem_dst,
              flag_v, flag_z, flag_n, redirect, redirect_pc, halted};
      expv = {m_valid, m_alu, m_store, m_re, m_we, m_rfwe, m_dst,
              m_v, m_z, m_n, m_squash, m_rpc, m_halted};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random_%0d: got %h expected %h", i, obs, expv);
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if ({br_total, br_taken} !== {16'(m_total), 16'(m_taken)}) begin
        errors++; $display("FAIL random_stats_%0d: got %h/%h expected %h/%h",
          i, br_total, br_taken, 16'(m_total), 16'(m_taken));
      end
`endif
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    do_reset();
    set_idle();
    ex_valid = 1; ex_branch = 1; ex_cond = 3'b001;
    for (int i = 0; i < 65540; i++) cycle();
    checks++;
    if ({br_total, br_taken} !== {16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL stats_saturate: total=%h taken=%h expected FFFF 0000", br_total, br_taken);
    end
    set_idle();
    ex_valid = 1; ex_jump = 1; ex_jmp_target = 16'h0010;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if ({br_total, br_taken} !== {16'hFFFF, 16'h0003}) begin
      errors++; $display("FAIL stats_taken: total=%h taken=%h expected FFFF 0003", br_total, br_taken);
    end
    do_reset();
    checks++;
    if ({br_total, br_taken} !== 32'h0) begin
      errors++; $display("FAIL stats_reset: total=%h taken=%h expected 0 0", br_total, br_taken);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_branch_eq();
    test_branch_lt();
    test_jump_stall();
    test_flush_taken();
    test_halt();
    test_reset_mid();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
